// File: rtl/imem_axi_loader_pkg.sv
// Shared AXI4-Lite definitions for the SoC interconnect slaves: response
// codes, write/read FSM encodings and the loader's default register map.
package soc_axi_pkg;

   localparam logic [1:0]  RESP_OKAY       = 2'b00;
   localparam logic [1:0]  RESP_SLVERR     = 2'b10;
   localparam logic [31:0] CTRL_OFFSET_DEF = 32'h0000_1000;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_EXEC = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_RESP = 1'b1
   } rd_state_t;

   // What a decoded write will do once it reaches W_EXEC
   typedef enum logic [1:0] {
      ACT_NONE = 2'd0,
      ACT_IMEM = 2'd1,
      ACT_CTRL = 2'd2
   } wr_act_t;

   // 9-bit counter increment that sticks at its maximum
   function automatic logic [8:0] sat_inc9(input logic [8:0] v);
      return (v == 9'h1FF) ? v : v + 9'd1;
   endfunction

endpackage

// File: rtl/imem_axi_loader_if.sv
// AXI4-Lite slave port bundle used by the instruction-memory loader.
interface imem_axi_loader_if;

   logic [31:0] s_awaddr;
   logic        s_awvalid;
   logic        s_awready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_wvalid;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready;
   logic [31:0] s_araddr;
   logic        s_arvalid;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready;

   modport slave (
      input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready,
      output s_awready, s_wready, s_bresp, s_bvalid,
             s_arready, s_rdata, s_rresp, s_rvalid
   );

   modport master (
      output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready,
      input  s_awready, s_wready, s_bresp, s_bvalid,
             s_arready, s_rdata, s_rresp, s_rvalid
   );

endinterface

// File: rtl/imem_axi_loader.sv
// AXI4-Lite slave that streams program words into the fetch-stage
// instruction memory while the core is held, and flushes fetch on release.
// Every output comes straight from a flop.
module imem_axi_loader
   import soc_axi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          IMEM_DEPTH  = 256,
   parameter logic [31:0] CTRL_OFFSET = CTRL_OFFSET_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   imem_axi_loader_if.slave bus,
   output logic             imem_write_en,
   output logic [7:0]       imem_write_addr,
   output logic [31:0]      imem_write_data,
   output logic             cpu_hold,
   output logic             cpu_flush
);

   localparam logic [31:0] IMEM_BYTES = 32'(IMEM_DEPTH * 4);

   wr_state_t   wstate, wstate_nxt;
   rd_state_t   rstate, rstate_nxt;

   logic        aw_vld_q, aw_vld_d, w_vld_q, w_vld_d;
   logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   wr_act_t     act_q, act_d, dec_act;
   logic [1:0]  resp_q, resp_d, dec_resp;

   logic        awready_q, awready_d, wready_q, wready_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        we_d, hold_d, flush_d;
   logic [7:0]  waddr_d;
   logic [31:0] wdat_d;
   logic [8:0]  cnt_q, cnt_d;

   logic        arready_q, arready_d, rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;

   logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [31:0] woff, roff;

   assign aw_hs = bus.s_awvalid & awready_q;
   assign w_hs  = bus.s_wvalid  & wready_q;
   assign b_hs  = bus.s_bready  & bvalid_q;
   assign ar_hs = bus.s_arvalid & arready_q;
   assign r_hs  = bus.s_rready  & rvalid_q;
   assign woff  = awaddr_q - BASE_ADDR;
   assign roff  = bus.s_araddr - BASE_ADDR;

   assign bus.s_awready = awready_q;
   assign bus.s_wready  = wready_q;
   assign bus.s_bvalid  = bvalid_q;
   assign bus.s_bresp   = bresp_q;
   assign bus.s_arready = arready_q;
   assign bus.s_rvalid  = rvalid_q;
   assign bus.s_rdata   = rdata_q;
   assign bus.s_rresp   = rresp_q;

   // Decode the latched write; alignment/strobe errors win over everything
   always_comb begin
      dec_act  = ACT_NONE;
      dec_resp = RESP_SLVERR;
      if (awaddr_q[1:0] == 2'b00 && wstrb_q == 4'hF) begin
         if (woff < IMEM_BYTES) begin
            if (cpu_hold) begin
               dec_act  = ACT_IMEM;
               dec_resp = RESP_OKAY;
            end
         end else if (woff == CTRL_OFFSET) begin
            dec_act  = ACT_CTRL;
            dec_resp = RESP_OKAY;
         end
      end
   end

   // Write FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wstate <= W_IDLE;
      else        wstate <= wstate_nxt;
   end

   // Write FSM next state
   always_comb begin
      wstate_nxt = wstate;
      case (wstate)
         W_IDLE:  if (aw_vld_q && w_vld_q) wstate_nxt = W_EXEC;
         W_EXEC:  wstate_nxt = W_RESP;
         W_RESP:  if (b_hs) wstate_nxt = W_IDLE;
         default: wstate_nxt = W_IDLE;
      endcase
   end

   // Write FSM outputs: next values for the channel latches and registered outputs
   always_comb begin
      aw_vld_d = aw_vld_q | aw_hs;
      w_vld_d  = w_vld_q  | w_hs;
      awaddr_d = aw_hs ? bus.s_awaddr : awaddr_q;
      wdata_d  = w_hs  ? bus.s_wdata  : wdata_q;
      wstrb_d  = w_hs  ? bus.s_wstrb  : wstrb_q;
      act_d    = act_q;
      resp_d   = resp_q;
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      we_d     = 1'b0;
      waddr_d  = imem_write_addr;
      wdat_d   = imem_write_data;
      hold_d   = cpu_hold;
      flush_d  = 1'b0;
      cnt_d    = cnt_q;
      case (wstate)
         W_IDLE: begin
            if (aw_vld_q && w_vld_q) begin
               act_d  = dec_act;
               resp_d = dec_resp;
               // Memory strobe is registered on entry so it is high for the W_EXEC cycle
               if (dec_act == ACT_IMEM) begin
                  we_d    = 1'b1;
                  waddr_d = woff[9:2];
                  wdat_d  = wdata_q;
               end
            end
         end
         W_EXEC: begin
            bvalid_d = 1'b1;
            bresp_d  = resp_q;
            if (act_q == ACT_IMEM) begin
               cnt_d = sat_inc9(cnt_q);
            end else if (act_q == ACT_CTRL) begin
               hold_d  = wdata_q[0];
               flush_d = cpu_hold & ~wdata_q[0];
               if (!cpu_hold && wdata_q[0]) cnt_d = 9'd0;
            end
         end
         W_RESP: begin
            if (b_hs) begin
               bvalid_d = 1'b0;
               aw_vld_d = 1'b0;
               w_vld_d  = 1'b0;
            end
         end
         default: ;
      endcase
      awready_d = (wstate_nxt == W_IDLE) && !aw_vld_d;
      wready_d  = (wstate_nxt == W_IDLE) && !w_vld_d;
   end

   // Write-side registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_vld_q        <= 1'b0;
         w_vld_q         <= 1'b0;
         awaddr_q        <= '0;
         wdata_q         <= '0;
         wstrb_q         <= '0;
         act_q           <= ACT_NONE;
         resp_q          <= RESP_OKAY;
         awready_q       <= 1'b1;
         wready_q        <= 1'b1;
         bvalid_q        <= 1'b0;
         bresp_q         <= RESP_OKAY;
         imem_write_en   <= 1'b0;
         imem_write_addr <= '0;
         imem_write_data <= '0;
         cpu_hold        <= 1'b1;
         cpu_flush       <= 1'b0;
         cnt_q           <= '0;
      end else begin
         aw_vld_q        <= aw_vld_d;
         w_vld_q         <= w_vld_d;
         awaddr_q        <= awaddr_d;
         wdata_q         <= wdata_d;
         wstrb_q         <= wstrb_d;
         act_q           <= act_d;
         resp_q          <= resp_d;
         awready_q       <= awready_d;
         wready_q        <= wready_d;
         bvalid_q        <= bvalid_d;
         bresp_q         <= bresp_d;
         imem_write_en   <= we_d;
         imem_write_addr <= waddr_d;
         imem_write_data <= wdat_d;
         cpu_hold        <= hold_d;
         cpu_flush       <= flush_d;
         cnt_q           <= cnt_d;
      end
   end

   // Read FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rstate <= R_IDLE;
      else        rstate <= rstate_nxt;
   end

   // Read FSM next state
   always_comb begin
      rstate_nxt = rstate;
      case (rstate)
         R_IDLE:  if (ar_hs) rstate_nxt = R_RESP;
         R_RESP:  if (r_hs)  rstate_nxt = R_IDLE;
         default: rstate_nxt = R_IDLE;
      endcase
   end

   // Read FSM outputs; status is sampled at AR acceptance, so a racing control write is not seen
   always_comb begin
      arready_d = (rstate_nxt == R_IDLE);
      rvalid_d  = (rstate_nxt == R_RESP);
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      if (ar_hs) begin
         if (roff == CTRL_OFFSET) begin
            rdata_d = {22'b0, cnt_q, cpu_hold};
            rresp_d = RESP_OKAY;
         end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
         end
      end
   end

   // Read-side registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

endmodule

// File: tb/tb_imem_axi_loader.sv
// Directed + randomized bench for the instruction-memory loader. A small
// reference model (hold flag, load counter) predicts responses, memory
// strobes, flush pulses and status reads.
module tb_imem_axi_loader;
   import soc_axi_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_write_en;
   logic [7:0]  imem_write_addr;
   logic [31:0] imem_write_data;
   logic        cpu_hold;
   logic        cpu_flush;

   imem_axi_loader_if bus();

   imem_axi_loader dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (bus),
      .imem_write_en   (imem_write_en),
      .imem_write_addr (imem_write_addr),
      .imem_write_data (imem_write_data),
      .cpu_hold        (cpu_hold),
      .cpu_flush       (cpu_flush)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic        m_hold;
   logic [8:0]  m_cnt;

   int          s_we_n, s_we_k, s_fl_n, s_fl_k, s_viol;
   logic [7:0]  s_we_addr;
   logic [31:0] s_we_data;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Record memory strobes and flush pulses seen at this negedge
   task automatic sample(input int k);
      if (imem_write_en) begin
         s_we_n++;
         s_we_k    = k;
         s_we_addr = imem_write_addr;
         s_we_data = imem_write_data;
      end
      if (cpu_flush) begin
         s_fl_n++;
         s_fl_k = k;
         if (!bus.s_bvalid) s_viol++;
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_hold"},    cpu_hold, 1);
      chk({tag, "_flush"},   cpu_flush, 0);
      chk({tag, "_we"},      imem_write_en, 0);
      chk({tag, "_waddr"},   imem_write_addr, 0);
      chk({tag, "_wdata"},   imem_write_data, 0);
      chk({tag, "_bvalid"},  bus.s_bvalid, 0);
      chk({tag, "_rvalid"},  bus.s_rvalid, 0);
      chk({tag, "_awready"}, bus.s_awready, 1);
      chk({tag, "_wready"},  bus.s_wready, 1);
      chk({tag, "_arready"}, bus.s_arready, 1);
      chk({tag, "_bresp"},   bus.s_bresp, 0);
      chk({tag, "_rresp"},   bus.s_rresp, 0);
      chk({tag, "_rdata"},   bus.s_rdata, 0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      m_hold = 1'b1;
      m_cnt  = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly);
      logic [1:0]  e_resp, g_resp;
      logic        e_we, e_flush, aw_done, w_done, hs_aw, hs_w;
      logic [7:0]  e_addr;
      logic [31:0] off;
      int          cyc, k, bv_k;
      // reference model
      off     = addr - 32'h0;
      e_we    = 1'b0;
      e_flush = 1'b0;
      e_addr  = '0;
      e_resp  = RESP_SLVERR;
      if (addr[1:0] == 2'b00 && strb == 4'hF) begin
         if (off < 32'd1024) begin
            if (m_hold) begin
               e_resp = RESP_OKAY;
               e_we   = 1'b1;
               e_addr = 8'(off / 4);
               if (m_cnt < 9'd511) m_cnt = m_cnt + 9'd1;
            end
         end else if (off == 32'h1000) begin
            e_resp = RESP_OKAY;
            if (m_hold && !data[0]) e_flush = 1'b1;
            if (!m_hold && data[0]) m_cnt = '0;
            m_hold = data[0];
         end
      end
      s_we_n = 0; s_we_k = 0; s_fl_n = 0; s_fl_k = 0; s_viol = 0;
      g_resp = 2'b01; bv_k = 0;
      aw_done = 1'b0; w_done = 1'b0; cyc = 0;
      while (!(aw_done && w_done) && cyc < 64) begin
         @(negedge clk);
         sample(0);
         if (aw_done && bus.s_awready) s_viol++;
         if (w_done && bus.s_wready) s_viol++;
         bus.s_awvalid = !aw_done && (cyc >= aw_dly);
         bus.s_awaddr  = addr;
         bus.s_wvalid  = !w_done && (cyc >= w_dly);
         bus.s_wdata   = data;
         bus.s_wstrb   = strb;
         hs_aw = bus.s_awvalid && bus.s_awready;
         hs_w  = bus.s_wvalid && bus.s_wready;
         @(posedge clk);
         if (hs_aw) aw_done = 1'b1;
         if (hs_w)  w_done  = 1'b1;
         cyc++;
      end
      chk("wr_accept", {aw_done, w_done}, 2'b11);
      k = 0;
      while (bv_k == 0 && k < 32) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            bus.s_awvalid = 1'b0;
            bus.s_wvalid  = 1'b0;
         end
         sample(k);
         if (bus.s_awready || bus.s_wready) s_viol++;
         if (bus.s_bvalid) begin
            bv_k   = k;
            g_resp = bus.s_bresp;
         end
      end
      repeat (b_dly) begin
         @(negedge clk);
         k++;
         sample(k);
         if (!bus.s_bvalid || bus.s_bresp !== g_resp || bus.s_awready || bus.s_wready) s_viol++;
      end
      @(negedge clk);
      k++;
      sample(k);
      if (!bus.s_bvalid) s_viol++;
      bus.s_bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      k++;
      sample(k);
      bus.s_bready = 1'b0;
      chk("wr_bvalid_drop", bus.s_bvalid, 0);
      chk("wr_awready_back", bus.s_awready, 1);
      @(negedge clk);
      k++;
      sample(k);
      chk("wr_b_latency", bv_k, 3);
      chk("wr_bresp", g_resp, e_resp);
      chk("wr_we_count", s_we_n, e_we);
      if (e_we) begin
         chk("wr_we_latency", s_we_k, 2);
         chk("wr_we_addr", s_we_addr, e_addr);
         chk("wr_we_data", s_we_data, data);
      end
      chk("wr_flush_count", s_fl_n, e_flush);
      if (e_flush) chk("wr_flush_latency", s_fl_k, 3);
      chk("wr_hold", cpu_hold, m_hold);
      chk("wr_stability", s_viol, 0);
   endtask

   task automatic do_read(input logic [31:0] addr, input int r_dly);
      logic [31:0] e_data, g_data;
      logic [1:0]  e_resp, g_resp;
      logic        done, hs;
      int          cyc, k, rv_k, viol;
      if (addr == 32'h1000) begin
         e_data = {22'b0, m_cnt, m_hold};
         e_resp = RESP_OKAY;
      end else begin
         e_data = '0;
         e_resp = RESP_SLVERR;
      end
      done = 1'b0; cyc = 0; viol = 0; rv_k = 0; k = 0;
      g_data = '0; g_resp = 2'b01;
      while (!done && cyc < 64) begin
         @(negedge clk);
         bus.s_arvalid = 1'b1;
         bus.s_araddr  = addr;
         hs = bus.s_arready;
         @(posedge clk);
         if (hs) done = 1'b1;
         cyc++;
      end
      chk("rd_accept", done, 1);
      while (rv_k == 0 && k < 32) begin
         @(negedge clk);
         k++;
         if (k == 1) bus.s_arvalid = 1'b0;
         if (bus.s_rvalid) begin
            rv_k   = k;
            g_data = bus.s_rdata;
            g_resp = bus.s_rresp;
         end
      end
      repeat (r_dly) begin
         @(negedge clk);
         if (!bus.s_rvalid || bus.s_rdata !== g_data || bus.s_rresp !== g_resp || bus.s_arready) viol++;
      end
      @(negedge clk);
      if (!bus.s_rvalid) viol++;
      bus.s_rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.s_rready = 1'b0;
      chk("rd_latency", rv_k, 1);
      chk("rd_rvalid_drop", bus.s_rvalid, 0);
      chk("rd_data", g_data, e_data);
      chk("rd_resp", g_resp, e_resp);
      chk("rd_stability", viol, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a, d;
      int          op;
      rst_n         = 1'b0;
      m_hold        = 1'b1;
      m_cnt         = '0;
      bus.s_awaddr  = '0; bus.s_awvalid = 1'b0;
      bus.s_wdata   = '0; bus.s_wstrb   = '0; bus.s_wvalid = 1'b0;
      bus.s_bready  = 1'b0;
      bus.s_araddr  = '0; bus.s_arvalid = 1'b0;
      bus.s_rready  = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("rst");
      rst_n = 1'b1;

      // same-cycle AW/W to word 2
      do_write(32'h0000_0008, 32'h0010_0093, 4'hF, 0, 0, 0);
      do_read(32'h0000_1000, 0);

      // W three cycles ahead of AW, top word
      apply_reset();
      do_write(32'h0000_03FC, 32'hDEAD_BEEF, 4'hF, 3, 0, 1);

      // release, then a write while running is refused
      do_write(32'h0000_1000, 32'h0, 4'hF, 0, 0, 0);
      do_write(32'h0000_0004, 32'h1234_5678, 4'hF, 0, 1, 0);
      do_read(32'h0000_1000, 2);

      // strobe / alignment / range errors
      do_write(32'h0000_0000, 32'hAAAA_5555, 4'h3, 0, 0, 0);
      do_write(32'h0000_0002, 32'hAAAA_5555, 4'hF, 1, 0, 0);
      do_write(32'h0000_0800, 32'hAAAA_5555, 4'hF, 0, 2, 0);
      do_read(32'h0000_0800, 1);

      // re-enter load mode (clears count), rewrite same value has no effect
      do_write(32'h0000_1000, 32'h1, 4'hF, 0, 0, 0);
      do_write(32'h0000_0010, 32'h0000_0013, 4'hF, 0, 0, 0);
      do_write(32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
      do_read(32'h0000_1000, 0);

      // slow B accept
      do_write(32'h0000_0020, 32'h0badf00d, 4'hF, 0, 0, 5);

      // randomized mix
      for (int i = 0; i < 60; i++) begin
         op = $urandom_range(0, 9);
         d  = $urandom;
         case (op)
            0, 1, 2, 3, 4: a = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            5:             a = 32'h0000_1000;
            6:             a = 32'h0000_1000;
            7:             a = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            8:             a = 32'h0000_0400 + 32'($urandom_range(0, 4000));
            default:       a = 32'($urandom_range(0, 8191));
         endcase
         if (op == 6 || op == 9)
            do_read(a, $urandom_range(0, 3));
         else
            do_write(a, d, (op == 7) ? 4'($urandom_range(0, 14)) : 4'hF,
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // load counter saturation
      do_write(32'h0000_1000, 32'h0, 4'hF, 0, 0, 0);
      do_write(32'h0000_1000, 32'h1, 4'hF, 0, 0, 0);
      for (int i = 0; i < 515; i++)
         do_write({22'b0, 8'(i), 2'b00}, $urandom, 4'hF, 0, 0, 0);
      do_read(32'h0000_1000, 0);

      // reset while the response is pending
      @(negedge clk);
      bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h0000_0040;
      bus.s_wvalid  = 1'b1; bus.s_wdata  = 32'h5555_AAAA; bus.s_wstrb = 4'hF;
      @(posedge clk);
      @(negedge clk);
      bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_bvalid_before_rst", bus.s_bvalid, 1);
      rst_n = 1'b0;
      #1;
      check_reset("mid");
      m_hold = 1'b1;
      m_cnt  = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // reset after AW only: the half-latched write must never reach memory
      @(negedge clk);
      bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h0000_0080;
      @(posedge clk);
      @(negedge clk);
      bus.s_awvalid = 1'b0;
      rst_n = 1'b0;
      s_we_n = 0; s_fl_n = 0; s_viol = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         sample(0);
      end
      chk("abort_no_we", s_we_n, 0);
      do_read(32'h0000_1000, 0);
      do_write(32'h0000_0084, 32'h0000_0073, 4'hF, 0, 0, 0);
      do_read(32'h0000_1000, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
